perf_bcd_conv: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3 / double dabble) for the TSP performance score.

---
 rtl/perf_bcd_conv.sv | 173 +++++++++++++++++
 tb/tb_perf_bcd_conv.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/perf_bcd_conv.sv
// -----------------------------------------------------------------------------
// perf_bcd_conv
//
// Sequential binary-to-BCD converter (shift-add-3 / double dabble) for the TSP
// performance score. It sits between tsp.performance and the seg7 digit
// drivers and produces DIGITS packed BCD nibbles plus an overflow flag, using
// one W-cycle iterative pass instead of combinational /10 %10 chains.
//
// Build option:
//   BCD_SATURATE_EN  defined   -> on overflow bcd_out is forced to all 9s
//                    undefined -> bcd_out is in_value mod 10**DIGITS
//   The overflow flag is produced identically in both builds.
//
// Parameters:
//   W        width of the unsigned binary input (at most 64)
//   DIGITS   number of BCD output digits
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   in_valid   in_value is valid; accepted when in_valid && in_ready
//   in_ready   converter can accept a new value (IDLE or DONE)
//   in_value   unsigned binary value to convert
//   out_valid  one-cycle pulse, high while bcd_out/overflow show a new result
//   bcd_out    packed BCD, [3:0] = ones; holds the last result
//   overflow   last result's in_value >= 10**DIGITS; holds with bcd_out
// -----------------------------------------------------------------------------
module perf_bcd_conv #(
    parameter int W      = 32,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_value,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    // Add 3 to every nibble that is 5 or more, so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
        logic [BW-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

`ifdef BCD_SATURATE_EN
    function automatic logic [BW-1:0] saturate(input logic [BW-1:0] raw,
                                               input logic          ovf);
        return ovf ? {DIGITS{4'h9}} : raw;
    endfunction
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf_out_q, ovf_out_d;

    logic            accept;
    logic [BW-1:0]   scratch_adj;
    logic [BW-1:0]   scratch_sh;

    // One double-dabble step: adjust, then shift the input MSB into the
    // scratch LSB. The top nibble's carry-out is dropped, which makes the
    // raw result in_value mod 10**DIGITS.
    always_comb begin
        scratch_adj = add3(scratch_q);
        scratch_sh  = {scratch_adj[BW-2:0], shreg_q[W-1]};
    end

    assign in_ready  = (state_q != SHIFT);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign bcd_out   = bcd_q;
    assign overflow  = ovf_out_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        ovf_out_d = ovf_out_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    shreg_d   = in_value;
                    scratch_d = '0;
                    cnt_d     = CW'(W - 1);
                    ovf_d     = (64'(in_value) >= LIMIT);
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                scratch_d = scratch_sh;
                shreg_d   = shreg_q << 1;
                if (cnt_q == '0) begin
                    // Last shift: the result lands in the output registers
                    // on the same edge that enters DONE, so bcd_out and
                    // out_valid line up.
                    state_d   = DONE;
`ifdef BCD_SATURATE_EN
                    bcd_d     = saturate(scratch_sh, ovf_q);
`else
                    bcd_d     = scratch_sh;
`endif
                    ovf_out_d = ovf_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            ovf_out_q <= ovf_out_d;
        end
    end

endmodule

// File: tb/tb_perf_bcd_conv.sv
module tb_perf_bcd_conv;

    localparam int W      = 32;
    localparam int DIGITS = 5;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_value;
    logic                out_valid;
    logic [4*DIGITS-1:0] bcd_out;
    logic                overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    perf_bcd_conv #(.W(W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .bcd_out   (bcd_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digits by plain division, 5-digit window.
    function automatic logic [19:0] model_bcd(input logic [31:0] v);
        longint unsigned r;
        logic [19:0]     b;
        r = 64'(v) % 64'd100000;
        b = '0;
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'(r % 64'd10);
            r = r / 64'd10;
        end
`ifdef BCD_SATURATE_EN
        if (v >= 32'd100000) b = 20'h99999;
`endif
        return b;
    endfunction

    function automatic logic model_ovf(input logic [31:0] v);
        return (64'(v) >= 64'd100000);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Convert one value from IDLE, checking latency, output stability during
    // SHIFT, the result, and that out_valid is a single-cycle pulse.
    task automatic run_conv(input logic [31:0] v, input string tag);
        int          k;
        bit          seen;
        bit          stable;
        logic [19:0] prev_bcd;
        logic        prev_ovf;
        @(negedge clk);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_value = $urandom;
        prev_bcd = bcd_out;
        prev_ovf = overflow;
        seen     = 1'b0;
        stable   = 1'b1;
        for (k = 1; k <= W + 10; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            if (bcd_out !== prev_bcd || overflow !== prev_ovf) stable = 1'b0;
            if (k == 5) chk({tag, "_busy"}, 64'(in_ready), 64'd0);
        end
        chk({tag, "_lat"}, seen ? 64'(k) : 64'hFFFF, 64'(W + 1));
        chk({tag, "_hold"}, 64'(stable), 64'd1);
        chk({tag, "_bcd"}, 64'(bcd_out), 64'(model_bcd(v)));
        chk({tag, "_ovf"}, 64'(overflow), 64'(model_ovf(v)));
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(out_valid), 64'd0);
        chk({tag, "_keep"}, 64'(bcd_out), 64'(model_bcd(v)));
    endtask

    initial begin
        int          t1;
        int          t2;
        int          k;
        bit          seen;
        logic [31:0] v;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bcd",  64'(bcd_out),   64'd0);
        chk("rst_ovf",  64'(overflow),  64'd0);
        chk("rst_rdy",  64'(in_ready),  64'd1);
        chk("rst_vld",  64'(out_valid), 64'd0);
        rst = 1'b0;

        run_conv(32'd0,      "zero");
        run_conv(32'd12345,  "d12345");
        run_conv(32'd99999,  "d99999");
        run_conv(32'd123456, "d123456");
        run_conv(32'd100000, "d100000");
        run_conv(32'hFFFFFFFF, "dmax");

        // Back-to-back with in_valid held high; a third value mid-SHIFT is ignored.
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 32'd7;
        @(posedge clk);
        #1;
        in_value = 32'd42;
        seen = 1'b0;
        t1 = 0;
        for (k = 1; k <= W + 10; k++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; t1 = cyc; break; end
        end
        chk("held7_seen", 64'(seen), 64'd1);
        chk("held7_bcd",  64'(bcd_out), 64'h00007);
        seen = 1'b0;
        t2 = 0;
        for (k = 1; k <= W + 10; k++) begin
            @(negedge clk);
            if (k == 10) in_value = 32'd999;
            if (k == 20) in_valid = 1'b0;
            if (out_valid) begin seen = 1'b1; t2 = cyc; break; end
        end
        chk("held42_seen", 64'(seen), 64'd1);
        chk("held42_gap",  64'(t2 - t1), 64'(W + 1));
        chk("held42_bcd",  64'(bcd_out), 64'h00042);
        seen = 1'b0;
        for (k = 1; k <= W + 10; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("third_ignored", 64'(seen), 64'd0);
        chk("third_bcd",     64'(bcd_out), 64'h00042);

        // Reset ten cycles into a conversion aborts it.
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 32'd54321;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_bcd", 64'(bcd_out),   64'd0);
        chk("abort_ovf", 64'(overflow),  64'd0);
        chk("abort_rdy", 64'(in_ready),  64'd1);
        chk("abort_vld", 64'(out_valid), 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (k = 1; k <= W + 10; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_novld", 64'(seen), 64'd0);
        run_conv(32'd54321, "d54321");

        // rst and in_valid together: the value is not accepted.
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_value = 32'd777;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rstwin_rdy", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (k = 1; k <= W + 10; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rstwin_novld", 64'(seen), 64'd0);
        chk("rstwin_bcd",   64'(bcd_out), 64'd0);

        // Randomized values: small, in-range, and full 32-bit.
        for (int i = 0; i < 24; i++) begin
            case (i % 3)
                0:       v = $urandom_range(0, 999);
                1:       v = $urandom_range(0, 199999);
                default: v = $urandom;
            endcase
            run_conv(v, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
